// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with saturating direction counters and
//   optional gshare global history. IF looks up the fetch PC combinationally;
//   EX reports resolved branches/jumps, which commit on the next rising edge.
//
// Handshake: there is no backpressure. lk_pc_i is sampled every cycle
//   (a stalled fetch re-presents the same PC). upd_valid_i qualifies the upd_*
//   bus for exactly one cycle per resolved instruction and is never stalled.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous invalidate of all state (beats update)
//   lk_pc_i                fetch PC
//   pred_hit_o/taken_o     BTB hit and direction prediction for lk_pc_i
//   pred_target_o          predicted target, 0 on miss
//   pred_ghr_o             history used for this lookup (0 when bimodal)
//   upd_*_i                resolved outcome plus the prediction carried down
//   mispredict_o           combinational flush request
//   branch_cnt_o           resolved updates (saturating)
//   mispredict_cnt_o       mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = PC_W - IDX_W - 2,
  localparam int GHW    = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [PC_W-1:0]  lk_pc_i,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  pred_target_o,
  output logic [GHW-1:0]   pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [PC_W-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [PC_W-1:0]  upd_pred_target_i,
  input  logic [GHW-1:0]   upd_ghr_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  if (PC_W < IDX_W + 3) begin : g_bad_pc_w
    $error("branch_predictor: PC_W must be >= IDX_W+3");
  end

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [GHW-1:0]   ghr_q, ghr_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  // History zero-extended or truncated to the index width; bimodal ignores it.
  function automatic logic [IDX_W-1:0] fold_ghr(input logic [GHW-1:0] g);
    logic [GHW+IDX_W-1:0] ext;
    ext = {{IDX_W{1'b0}}, g};
    return (GHR_W > 0) ? ext[IDX_W-1:0] : '0;
  endfunction

  // Lookup path
  logic [IDX_W-1:0] lk_idx, lk_cidx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx        = lk_pc_i[IDX_W+1:2];
  assign lk_tag        = lk_pc_i[PC_W-1:IDX_W+2];
  assign lk_cidx       = lk_idx ^ fold_ghr(ghr_q);
  assign pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && ctr_q[lk_cidx][CTR_W-1];
  assign pred_target_o = pred_hit_o ? tgt_q[lk_idx] : '0;
  assign pred_ghr_o    = ghr_q;

  assign mispredict_o = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  // Update path: counter index uses the history the prediction was made with.
  logic [IDX_W-1:0] upd_idx, upd_cidx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr, ctr_d;

  assign upd_idx  = upd_pc_i[IDX_W+1:2];
  assign upd_tag  = upd_pc_i[PC_W-1:IDX_W+2];
  assign upd_cidx = upd_idx ^ fold_ghr(upd_ghr_i);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr  = ctr_q[upd_cidx];

  always_comb begin
    ctr_d = upd_ctr;
    if (upd_taken_i) begin
      if (!upd_hit)                ctr_d = CTR_WT;  // fresh allocation
      else if (upd_ctr != CTR_MAX) ctr_d = upd_ctr + 1'b1;
    end else if (upd_ctr != '0) begin
      ctr_d = upd_ctr - 1'b1;  // decrements even on a BTB miss
    end
  end

  assign ghr_d = (GHR_W > 0) ? ((ghr_q << 1) | GHW'(upd_taken_i)) : '0;

  assign branch_cnt_d     = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + 1'b1;
  assign mispredict_cnt_d = (!mispredict_o || mispredict_cnt_q == '1) ?
                            mispredict_cnt_q : mispredict_cnt_q + 1'b1;

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      ghr_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      ghr_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (upd_valid_i) begin
      // Taken outcomes (re)write the entry: a hit keeps its tag, a miss
      // allocates over whatever alias lived there.
      if (upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target_i;
      end
      ctr_q[upd_cidx]  <= ctr_d;
      ghr_q            <= ghr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Byte-offset bits of the PCs carry no information for this block.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Two instances share stimulus: index 0 is bimodal with 4-bit statistics,
// index 1 is gshare with 4 bits of history and 16-bit statistics.
module tb_branch_predictor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [8:0] lk_pc, upd_pc, upd_target, upd_pred_target;
  logic       upd_valid, upd_taken, upd_pred_taken;
  logic [0:0] upd_ghr_b;
  logic [3:0] upd_ghr_g;

  logic       pred_hit [2];
  logic       pred_taken [2];
  logic       mispredict [2];
  logic [8:0] pred_target [2];
  logic [0:0] pred_ghr_b;
  logic [3:0] pred_ghr_g;
  logic [3:0] bcnt_b, mcnt_b;
  logic [15:0] bcnt_g, mcnt_g;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CTR_W(2), .GHR_W(0), .CNT_W(4)) u_bim (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .lk_pc_i(lk_pc),
    .pred_hit_o(pred_hit[0]), .pred_taken_o(pred_taken[0]),
    .pred_target_o(pred_target[0]), .pred_ghr_o(pred_ghr_b),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .upd_ghr_i(upd_ghr_b),
    .mispredict_o(mispredict[0]), .branch_cnt_o(bcnt_b), .mispredict_cnt_o(mcnt_b)
  );

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CTR_W(2), .GHR_W(4), .CNT_W(16)) u_gsh (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .lk_pc_i(lk_pc),
    .pred_hit_o(pred_hit[1]), .pred_taken_o(pred_taken[1]),
    .pred_target_o(pred_target[1]), .pred_ghr_o(pred_ghr_g),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .upd_ghr_i(upd_ghr_g),
    .mispredict_o(mispredict[1]), .branch_cnt_o(bcnt_g), .mispredict_cnt_o(mcnt_g)
  );

  // ---------------- reference model ----------------
  int m_valid [2][16];
  int m_tag   [2][16];
  int m_tgt   [2][16];
  int m_ctr   [2][16];
  int m_ghr   [2];
  int m_bcnt  [2];
  int m_mcnt  [2];
  int cnt_max [2] = '{15, 65535};

  function automatic int m_idx(int pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int m_cidx(int k, int pc, int g);
    return (k == 1) ? (m_idx(pc) ^ (g % 16)) : m_idx(pc);
  endfunction

  function automatic int m_hit(int k, int pc);
    return (m_valid[k][m_idx(pc)] != 0 && m_tag[k][m_idx(pc)] == pc / 64) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[k][i] = 0; m_tag[k][i] = 0; m_tgt[k][i] = 0; m_ctr[k][i] = 1;
      end
      m_ghr[k] = 0; m_bcnt[k] = 0; m_mcnt[k] = 0;
    end
  endtask

  function automatic int exp_mispredict();
    return (upd_valid && ((upd_pred_taken != upd_taken) ||
            (upd_taken && upd_pred_target != upd_target))) ? 1 : 0;
  endfunction

  task automatic m_commit();
    int ci, ix, h, mp;
    mp = exp_mispredict();
    if (!rst_n || clear) begin
      m_reset();
    end else if (upd_valid) begin
      for (int k = 0; k < 2; k++) begin
        ix = m_idx(int'(upd_pc));
        ci = m_cidx(k, int'(upd_pc), (k == 1) ? int'(upd_ghr_g) : 0);
        h  = m_hit(k, int'(upd_pc));
        if (upd_taken) begin
          if (h != 0) begin
            if (m_ctr[k][ci] < 3) m_ctr[k][ci] = m_ctr[k][ci] + 1;
          end else begin
            m_valid[k][ix] = 1;
            m_tag[k][ix]   = int'(upd_pc) / 64;
            m_ctr[k][ci]   = 2;
          end
          m_tgt[k][ix] = int'(upd_target);
        end else if (m_ctr[k][ci] > 0) begin
          m_ctr[k][ci] = m_ctr[k][ci] - 1;
        end
        m_ghr[k] = (k == 1) ? ((m_ghr[k] * 2 + (upd_taken ? 1 : 0)) % 16) : 0;
        if (m_bcnt[k] < cnt_max[k]) m_bcnt[k] = m_bcnt[k] + 1;
        if (mp != 0 && m_mcnt[k] < cnt_max[k]) m_mcnt[k] = m_mcnt[k] + 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output of both instances against the model, then let the
  // clock edge commit and advance the model to match.
  task automatic step();
    int h, t, tg, mp;
    #1;
    mp = exp_mispredict();
    for (int k = 0; k < 2; k++) begin
      h  = m_hit(k, int'(lk_pc));
      t  = (h != 0 && m_ctr[k][m_cidx(k, int'(lk_pc), m_ghr[k])] >= 2) ? 1 : 0;
      tg = (h != 0) ? m_tgt[k][m_idx(int'(lk_pc))] : 0;
      chk($sformatf("hit%0d", k),    32'(pred_hit[k]), h);
      chk($sformatf("taken%0d", k),  32'(pred_taken[k]), t);
      chk($sformatf("target%0d", k), 32'(pred_target[k]), tg);
      chk($sformatf("ghr%0d", k),    (k == 0) ? 32'(pred_ghr_b) : 32'(pred_ghr_g), m_ghr[k]);
      chk($sformatf("mispred%0d", k), 32'(mispredict[k]), mp);
      chk($sformatf("bcnt%0d", k),   (k == 0) ? 32'(bcnt_b) : 32'(bcnt_g), m_bcnt[k]);
      chk($sformatf("mcnt%0d", k),   (k == 0) ? 32'(mcnt_b) : 32'(mcnt_g), m_mcnt[k]);
    end
    m_commit();
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [8:0] lk, input logic uv, input logic [8:0] upc,
                       input logic ut, input logic [8:0] utgt,
                       input logic upt, input logic [8:0] uptgt);
    int g;
    g               = m_ghr[1];
    clear           = 1'b0;
    lk_pc           = lk;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    upd_ghr_b       = 1'b0;
    upd_ghr_g       = g[3:0];
  endtask

  task automatic idle(input logic [8:0] lk);
    drive(lk, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 9'h0);
  endtask

  function automatic logic [8:0] rand_pc();
    return 9'(($urandom_range(0, 1) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle(9'h0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    idle(9'h010); #1;
    chk("rst_hit", 32'(pred_hit[0]), 0);
    chk("rst_taken", 32'(pred_taken[0]), 0);
    chk("rst_target", 32'(pred_target[0]), 0);
    chk("rst_bcnt", 32'(bcnt_b), 0);
    chk("rst_mcnt", 32'(mcnt_b), 0);
    step();

    // Allocate on a taken miss
    drive(9'h010, 1'b1, 9'h010, 1'b1, 9'h040, 1'b0, 9'h000); #1;
    chk("alloc_mispredict", 32'(mispredict[0]), 1);
    step();
    idle(9'h010); #1;
    chk("alloc_hit", 32'(pred_hit[0]), 1);
    chk("alloc_taken", 32'(pred_taken[0]), 1);
    chk("alloc_target", 32'(pred_target[0]), 32'h040);
    chk("alloc_bcnt", 32'(bcnt_b), 1);
    chk("alloc_mcnt", 32'(mcnt_b), 1);
    step();

    // Counter training and saturation
    drive(9'h010, 1'b1, 9'h010, 1'b0, 9'h000, 1'b1, 9'h040); step();
    idle(9'h010); #1;
    chk("train_nt_taken", 32'(pred_taken[0]), 0);
    chk("train_nt_hit", 32'(pred_hit[0]), 1);
    step();
    drive(9'h010, 1'b1, 9'h010, 1'b0, 9'h000, 1'b0, 9'h000); step();
    repeat (5) begin
      drive(9'h010, 1'b1, 9'h010, 1'b1, 9'h040, 1'b0, 9'h040); step();
    end
    drive(9'h010, 1'b1, 9'h010, 1'b0, 9'h000, 1'b1, 9'h040); step();
    idle(9'h010); #1;
    chk("sat_still_taken", 32'(pred_taken[0]), 1);
    step();

    // Aliasing
    idle(9'h050); #1; chk("alias_miss", 32'(pred_hit[0]), 0); step();
    drive(9'h050, 1'b1, 9'h050, 1'b1, 9'h100, 1'b0, 9'h000); step();
    idle(9'h050); #1;
    chk("alias_hit", 32'(pred_hit[0]), 1);
    chk("alias_target", 32'(pred_target[0]), 32'h100);
    step();
    idle(9'h010); #1; chk("alias_evicted", 32'(pred_hit[0]), 0); step();
    drive(9'h014, 1'b1, 9'h014, 1'b0, 9'h000, 1'b0, 9'h000); step();
    idle(9'h014); #1; chk("nt_no_alloc", 32'(pred_hit[0]), 0); step();

    // Simultaneity
    drive(9'h050, 1'b1, 9'h050, 1'b1, 9'h0a0, 1'b1, 9'h100); #1;
    chk("same_cycle_old_target", 32'(pred_target[0]), 32'h100);
    step();
    idle(9'h050); #1; chk("new_target", 32'(pred_target[0]), 32'h0a0); step();
    drive(9'h018, 1'b1, 9'h018, 1'b1, 9'h060, 1'b0, 9'h000); clear = 1'b1; step();
    idle(9'h018); #1;
    chk("clear_drop_hit", 32'(pred_hit[0]), 0);
    chk("clear_bcnt", 32'(bcnt_b), 0);
    step();
    repeat (20) begin
      drive(9'h01c, 1'b1, 9'h01c, 1'b1, 9'h070, 1'b1, 9'h070); step();
    end
    idle(9'h01c); #1; chk("bcnt_saturated", 32'(bcnt_b), 15); step();

    // gshare history
    idle(9'h020); clear = 1'b1; step();
    drive(9'h020, 1'b1, 9'h020, 1'b1, 9'h080, 1'b0, 9'h000); step();
    drive(9'h020, 1'b1, 9'h020, 1'b1, 9'h080, 1'b1, 9'h080); step();
    drive(9'h020, 1'b1, 9'h020, 1'b0, 9'h000, 1'b1, 9'h080); step();
    drive(9'h020, 1'b1, 9'h020, 1'b1, 9'h080, 1'b0, 9'h000); step();
    idle(9'h020); #1;
    chk("ghr_1101", 32'(pred_ghr_g), 32'hd);
    chk("gsh_cidx_taken", 32'(pred_taken[1]), 0);
    chk("bim_taken", 32'(pred_taken[0]), 1);
    step();

    // Asynchronous reset in the middle of an update
    drive(9'h020, 1'b1, 9'h024, 1'b1, 9'h090, 1'b0, 9'h000);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_hit%0d", k), 32'(pred_hit[k]), 0);
      chk($sformatf("arst_taken%0d", k), 32'(pred_taken[k]), 0);
      chk($sformatf("arst_target%0d", k), 32'(pred_target[k]), 0);
      chk($sformatf("arst_mispred%0d", k), 32'(mispredict[k]), 1);
    end
    chk("arst_ghr", 32'(pred_ghr_g), 0);
    chk("arst_bcnt", 32'(bcnt_g), 0);
    chk("arst_mcnt", 32'(mcnt_b), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(9'h024); #1;
    chk("arst_update_lost", 32'(pred_hit[0]), 0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] upc;
      int g;
      upc = rand_pc();
      drive(rand_pc(), ($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)),
            9'($urandom_range(0, 511)), 1'b0, 9'h0);
      if ($urandom_range(0, 1) == 1) begin
        upd_pred_taken  = (m_hit(0, int'(upc)) != 0 && m_ctr[0][m_cidx(0, int'(upc), 0)] >= 2);
        g               = (m_hit(0, int'(upc)) != 0) ? m_tgt[0][m_idx(int'(upc))] : 0;
        upd_pred_target = g[8:0];
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = 9'($urandom_range(0, 511));
      end
      if ($urandom_range(0, 4) == 0) upd_ghr_g = 4'($urandom_range(0, 15));
      upd_ghr_b = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
